// File: rtl/core_sequencer_if.sv
// Sequencer-side bus: instruction memory port plus execute-stage
// operand/control outputs and result inputs.
interface core_sequencer_if #(
  parameter int AW = 10
);
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic [31:0]   pc;
  logic [5:0]    instr;
  logic [1:0]    op_type;
  logic [31:0]   s;
  logic [31:0]   t;
  logic [31:0]   imm;
  logic          branch;
  logic          jump;
  logic          is_jr;
  logic          start;
  logic [31:0]   d;
  logic [31:0]   npc;
  logic          uart_state;
  logic          halted;

  modport master (
    output imem_addr, pc, instr, op_type, s, t, imm,
    output branch, jump, is_jr, start, halted,
    input  imem_data, d, npc, uart_state
  );

  modport slave (
    input  imem_addr, pc, instr, op_type, s, t, imm,
    input  branch, jump, is_jr, start, halted,
    output imem_data, d, npc, uart_state
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/regfile stage feeding execute; writes back
// execute's result and follows its next-pc.
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          EXEC_CYCLES = 3,
  parameter int          IMEM_AW     = 10
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] mode,
  core_sequencer_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_IO     = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_FPU   = 6'b010001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LW_S  = 6'b110001;
  localparam logic [5:0] OP_IN    = 6'b111110;
  localparam logic [5:0] OP_OUT   = 6'b111111;
  localparam logic [5:0] F_JR     = 6'b001000;

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [1:0]  io_ph;
  logic [31:0] pc;
  logic [5:0]  instr;
  logic [1:0]  op_type;
  logic [31:0] s, t, imm;
  logic        branch, jump, is_jr, start, halted;
  logic        wb_en;
  logic [4:0]  wb_dst;
  logic [31:0] rf [32];

  logic [31:0] iw;
  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, fd;
  logic        run;

  assign iw  = bus.imem_data;
  assign opc = iw[31:26];
  assign fn  = iw[5:0];
  assign rs  = iw[25:21];
  assign rt  = iw[20:16];
  assign rd  = iw[15:11];
  assign fd  = iw[10:6];
  assign run = (mode == 3'd2);

  logic [5:0]  instr_n;
  logic [1:0]  op_type_n;
  logic [31:0] s_n, t_n, imm_n;
  logic        br_n, jmp_n, jr_n, io_n, wen_n;
  logic [4:0]  dst_n;

  always_comb begin
    instr_n   = opc;
    op_type_n = 2'd0;
    s_n       = (rs == 5'd0) ? 32'd0 : rf[rs];
    t_n       = (rt == 5'd0) ? 32'd0 : rf[rt];
    imm_n     = {{16{iw[15]}}, iw[15:0]};
    br_n      = 1'b0;
    jmp_n     = 1'b0;
    jr_n      = 1'b0;
    io_n      = 1'b0;
    wen_n     = 1'b0;
    dst_n     = rt;
    unique case (1'b1)
      (opc == OP_R): begin
        op_type_n = 2'd1;
        instr_n   = fn;
        dst_n     = rd;
        jr_n      = (fn == F_JR);
        case (fn)
          6'b000000, 6'b000010, 6'b000011, 6'b000100,
          6'b000110, 6'b000111, 6'b100000, 6'b100001,
          6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011:
            wen_n = 1'b1;
          default: wen_n = 1'b0;
        endcase
      end
      (opc == OP_FPU): begin
        op_type_n = 2'd2;
        instr_n   = fn;
        dst_n     = fd;
        wen_n     = (fn[5:3] == 3'b000);
      end
      (opc == OP_J || opc == OP_JAL): begin
        imm_n = {6'b0, iw[25:0]};
        jmp_n = 1'b1;
        if (opc == OP_JAL) begin
          s_n   = pc + 32'd4;
          wen_n = 1'b1;
          dst_n = 5'd31;
        end
      end
      default: begin
        io_n = (opc == OP_IN) || (opc == OP_OUT);
        case (opc)
          OP_ANDI, OP_ORI, OP_XORI: begin
            imm_n = {16'b0, iw[15:0]};
            wen_n = 1'b1;
          end
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_LUI, OP_LW, OP_LW_S, OP_IN:
            wen_n = 1'b1;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
            br_n = 1'b1;
          default: wen_n = 1'b0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      cnt     <= '0;
      io_ph   <= '0;
      instr   <= '0;
      op_type <= '0;
      s       <= '0;
      t       <= '0;
      imm     <= '0;
      branch  <= 1'b0;
      jump    <= 1'b0;
      is_jr   <= 1'b0;
      start   <= 1'b0;
      halted  <= 1'b0;
      wb_en   <= 1'b0;
      wb_dst  <= '0;
    end else if (!run) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      start  <= 1'b0;
      halted <= 1'b0;
      branch <= 1'b0;
      jump   <= 1'b0;
      is_jr  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (iw == 32'hFFFF_FFFF) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            instr   <= instr_n;
            op_type <= op_type_n;
            s       <= s_n;
            t       <= t_n;
            imm     <= imm_n;
            branch  <= br_n;
            jump    <= jmp_n;
            is_jr   <= jr_n;
            start   <= io_n;
            wb_en   <= wen_n;
            wb_dst  <= dst_n;
            cnt     <= '0;
            io_ph   <= '0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          start <= 1'b0;
          if (start)
            state <= S_IO;
          else if (cnt == 4'(EXEC_CYCLES - 1))
            state <= S_WB;
          else
            cnt <= cnt + 4'd1;
        end
        // busy only rises the cycle after start, so phase 0 skips it
        S_IO: begin
          case (io_ph)
            2'd0: io_ph <= 2'd1;
            2'd1: if (!bus.uart_state) io_ph <= 2'd2;
            default: state <= S_WB;
          endcase
        end
        S_WB: begin
          pc     <= bus.npc;
          branch <= 1'b0;
          jump   <= 1'b0;
          is_jr  <= 1'b0;
          state  <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (run && state == S_WB && wb_en && wb_dst != 5'd0) begin
      rf[wb_dst] <= bus.d;
    end
  end

  assign bus.imem_addr = pc[IMEM_AW+1:2];
  assign bus.pc        = pc;
  assign bus.instr     = instr;
  assign bus.op_type   = op_type;
  assign bus.s         = s;
  assign bus.t         = t;
  assign bus.imm       = imm;
  assign bus.branch    = branch;
  assign bus.jump      = jump;
  assign bus.is_jr     = is_jr;
  assign bus.start     = start;
  assign bus.halted    = halted;
endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench: small program in a bench-owned ROM, execute stage
// played by the stimulus, checks on operands, pc flow and control.
module tb_core_sequencer;
  logic       clk;
  logic       rstn;
  logic [2:0] mode;
  int         checks;
  int         errors;
  int         n;
  logic [31:0] mem [1024];

  core_sequencer_if #(.AW(10)) bus ();

  core_sequencer #(
    .RESET_PC(32'h0), .EXEC_CYCLES(3), .IMEM_AW(10)
  ) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of a FETCH cycle, leaves at the next one.
  task automatic run_instr(input string tag, input logic [31:0] epc,
                           input logic [5:0] e_instr,
                           input logic [1:0] e_ot,
                           input logic [31:0] e_s, input logic [31:0] e_t,
                           input logic [31:0] e_imm,
                           input logic [2:0] e_flags,
                           input logic [31:0] dval,
                           input logic [31:0] npcv);
    chk({tag, ".pc"}, bus.pc, epc);
    chk({tag, ".iaddr"}, 32'(bus.imem_addr), {22'd0, epc[11:2]});
    bus.d   = 32'hBAD0_BAD0;
    bus.npc = npcv;
    repeat (2) @(negedge clk);
    chk({tag, ".instr"}, 32'(bus.instr), 32'(e_instr));
    chk({tag, ".optype"}, 32'(bus.op_type), 32'(e_ot));
    chk({tag, ".s"}, bus.s, e_s);
    chk({tag, ".t"}, bus.t, e_t);
    chk({tag, ".imm"}, bus.imm, e_imm);
    chk({tag, ".flags"}, {29'd0, bus.branch, bus.jump, bus.is_jr},
        {29'd0, e_flags});
    chk({tag, ".start"}, 32'(bus.start), 32'd0);
    repeat (3) @(negedge clk);
    bus.d = dval;
    @(negedge clk);
    chk({tag, ".npc"}, bus.pc, npcv);
    chk({tag, ".clr"}, {29'd0, bus.branch, bus.jump, bus.is_jr}, 32'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rstn           = 1'b0;
    mode           = 3'd0;
    bus.d          = '0;
    bus.npc        = '0;
    bus.uart_state = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[0]     = 32'h2001_0005;
    mem[1]     = 32'h0021_1020;
    mem[2]     = 32'h0C00_0100;
    mem[10'h100] = 32'h005F_1820;
    mem[10'h101] = 32'h1021_0010;
    mem[10'h010] = 32'h2000_0007;
    mem[10'h011] = 32'h3004_FFFF;
    mem[10'h012] = 32'h2005_FFFF;
    mem[10'h013] = 32'hFCA0_0000;
    mem[10'h014] = 32'h8CA6_0000;
    mem[10'h015] = 32'h00C4_3820;
    mem[10'h016] = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    chk("rst.pc", bus.pc, 32'd0);
    chk("rst.start", 32'(bus.start), 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.optype", 32'(bus.op_type), 32'd0);
    chk("rst.s", bus.s, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle.pc", bus.pc, 32'd0);
    mode = 3'd2;
    @(negedge clk);

    run_instr("addi_r1", 32'h0, 6'h08, 2'd0, 32'd0, 32'd0,
              32'd5, 3'b000, 32'd5, 32'h4);
    run_instr("add_r2", 32'h4, 6'h20, 2'd1, 32'd5, 32'd5,
              32'h1020, 3'b000, 32'd10, 32'h8);
    run_instr("jal", 32'h8, 6'h03, 2'd0, 32'd12, 32'd0,
              32'h100, 3'b010, 32'd12, 32'h400);
    run_instr("add_r3", 32'h400, 6'h20, 2'd1, 32'd10, 32'd12,
              32'h1820, 3'b000, 32'd22, 32'h404);
    run_instr("beq", 32'h404, 6'h04, 2'd0, 32'd5, 32'd5,
              32'h10, 3'b100, 32'd1, 32'h40);
    run_instr("addi_r0", 32'h40, 6'h08, 2'd0, 32'd0, 32'd0,
              32'd7, 3'b000, 32'd7, 32'h44);
    run_instr("andi_r4", 32'h44, 6'h0C, 2'd0, 32'd0, 32'd0,
              32'h0000_FFFF, 3'b000, 32'd0, 32'h48);
    run_instr("addi_r5", 32'h48, 6'h08, 2'd0, 32'd0, 32'd0,
              32'hFFFF_FFFF, 3'b000, 32'hDEAD_BEEF, 32'h4C);

    chk("out.pc", bus.pc, 32'h4C);
    bus.d   = 32'hBAD0_BAD0;
    bus.npc = 32'h50;
    repeat (2) @(negedge clk);
    chk("out.start1", 32'(bus.start), 32'd1);
    chk("out.instr", 32'(bus.instr), 32'h3F);
    chk("out.s", bus.s, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("out.start0", 32'(bus.start), 32'd0);
    bus.uart_state = 1'b1;
    repeat (7) @(negedge clk);
    bus.uart_state = 1'b0;
    chk("out.hold", bus.pc, 32'h4C);
    n = 0;
    while (bus.pc != 32'h50 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("out.lat", 32'(n), 32'd3);
    chk("out.npc", bus.pc, 32'h50);

    run_instr("lw_r6", 32'h50, 6'h23, 2'd0, 32'hDEAD_BEEF, 32'd0,
              32'd0, 3'b000, 32'h1234_5678, 32'h54);
    run_instr("add_r7", 32'h54, 6'h20, 2'd1, 32'h1234_5678, 32'd0,
              32'h3820, 3'b000, 32'd0, 32'h58);

    chk("halt.pc", bus.pc, 32'h58);
    repeat (2) @(negedge clk);
    chk("halt.set", 32'(bus.halted), 32'd1);
    repeat (4) @(negedge clk);
    chk("halt.stick", 32'(bus.halted), 32'd1);
    chk("halt.pchold", bus.pc, 32'h58);
    mode = 3'd0;
    @(negedge clk);
    chk("halt.clr", 32'(bus.halted), 32'd0);
    chk("halt.pcrst", bus.pc, 32'd0);

    mem[0] = 32'hFC00_0000;
    mode   = 3'd2;
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("io2.start", 32'(bus.start), 32'd1);
    @(negedge clk);
    bus.uart_state = 1'b1;
    @(negedge clk);
    mode = 3'd0;
    @(negedge clk);
    chk("drop.pc", bus.pc, 32'd0);
    chk("drop.start", 32'(bus.start), 32'd0);
    bus.uart_state = 1'b0;
    mem[0] = 32'h2001_0005;
    mode   = 3'd2;
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("redo.instr", 32'(bus.instr), 32'h08);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("arst.pc", bus.pc, 32'd0);
    chk("arst.instr", 32'(bus.instr), 32'd0);
    chk("arst.imm", bus.imm, 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    mem[0] = 32'h0021_1020;
    @(negedge clk);
    run_instr("rf_clr", 32'h0, 6'h20, 2'd1, 32'd0, 32'd0,
              32'h1020, 3'b000, 32'd0, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
